// File: rtl/ram_fifo.sv
// ---------------------------------------------------------------------------
// ram_fifo
//
// Synchronous first-word-fall-through FIFO built on a register-array RAM.
// Producer and consumer share one clock. Internal write and read pointers
// address the array. Occupancy is kept in its own register, so full and
// empty are never ambiguous.
//
// Ports:
//   clk          - single clock, all state changes on the rising edge
//   rst_n        - asynchronous active-low reset (clears storage as well)
//   clear        - synchronous flush of pointers, count and pulses
//   push         - enqueue request, push_data is the word to store
//   pop          - dequeue request
//   pop_data     - head-of-queue word, meaningful only while empty=0
//   count        - current occupancy, 0..D
//   full/empty   - count == D / count == 0
//   almost_full  - count >= AFULL_TH
//   almost_empty - count <= AEMPTY_TH
//   overflow     - one-cycle pulse following a rejected push
//   underflow    - one-cycle pulse following a rejected pop
// ---------------------------------------------------------------------------
module ram_fifo #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 4,
   parameter int AFULL_TH   = 14,
   parameter int AEMPTY_TH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int                Depth       = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DepthCount  = Depth[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AfullLevel  = AFULL_TH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AemptyLevel = AEMPTY_TH[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem_q [Depth];

   logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
   logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic                  pushAcc;
   logic                  popAcc;
   logic                  fullNow;
   logic                  emptyNow;

   // Status flags are pure decodes of the count register, so they only move
   // after a clock edge and cannot glitch on request inputs.
   always_comb begin
      fullNow      = (count_q == DepthCount);
      emptyNow     = (count_q == '0);
      full         = fullNow;
      empty        = emptyNow;
      almost_full  = (count_q >= AfullLevel);
      almost_empty = (count_q <= AemptyLevel);
      count        = count_q;
      overflow     = overflow_q;
      underflow    = underflow_q;
   end

   // Head of queue falls straight through from the registered read pointer.
   assign pop_data = mem_q[rdPtr_q];

   // Request acceptance. A pop frees a slot in the same cycle, so a full queue
   // still takes a push when it is paired with a pop. An empty queue never
   // pairs that way: the pop has nothing to return. clear overrides both.
   always_comb begin
      popAcc  = pop & ~clear & ~emptyNow;
      pushAcc = push & ~clear & (~fullNow | popAcc);
   end

   // Next-state for pointers, occupancy and the rejection pulses. A flush
   // drops everything back to the start position but leaves storage alone;
   // the old words become unreachable once the pointers reset.
   always_comb begin
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      count_d     = count_q;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;

      if (clear) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (pushAcc) begin
            wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
         end
         if (popAcc) begin
            rdPtr_d = rdPtr_q + ADDR_WIDTH'(1);
         end
         case ({pushAcc, popAcc})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
         endcase
         overflow_d  = push & ~pushAcc;
         underflow_d = pop & ~popAcc;
      end
   end

   // Control state register. Pointers wrap naturally because they are
   // exactly ADDR_WIDTH bits wide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage array. Reset zeroes every word so pop_data reads zero straight
   // out of reset; a flush deliberately does not touch it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else if (pushAcc) begin
         mem_q[wrPtr_q] <= push_data;
      end
   end

endmodule
